irq_scheduler: RTL
==================

Name: irq_scheduler

Overview:
Multi-source interrupt controller that replaces the single-source timer-to-rom interrupt path. It latches requests from up to NUM_SRC peripherals (timer, button, random-ready, spare), applies a software mask, and picks one winner. It then drives a held jump request with a per-source vector to rom, and tracks the in-service state until the decoder's return-from-interrupt clears it. It sits between the peripherals/registers file and rom/decoder.

Parameters:
NUM_SRC, 4, number of request inputs (1..8).
VEC_BASE, 8'hE0, ROM address of source 0 handler.
VEC_STRIDE, 8, ROM address spacing between handlers.

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
irq_req  in  NUM_SRC  per-source request; a single-cycle pulse suffices
global_enable  in  1  master interrupt enable from registers file
mask_w_enable  in  1  write strobe for mask register
mask_w_data  in  8  new mask; bit i = 1 enables source i (bits >= NUM_SRC ignored)
mask  out  NUM_SRC  current mask, for register readback
pending  out  NUM_SRC  latched, not-yet-dispatched requests
jump  out  1  vector jump request to rom; held until jump_ack
jump_vector  out  8  handler address, valid while jump = 1
jump_ack  in  1  rom accepted jump (return PC pushed) on this edge
clear_status  in  1  one-cycle pulse from decoder on return-from-interrupt
status  out  1  high from dispatch until clear_status is accepted
active_id  out  3  index of the source being dispatched or serviced

Behaviour:
- Reset values: mask = all ones, pending = 0, jump = 0, jump_vector = 0, status = 0, active_id = 0, state = IDLE, round-robin pointer = 0.
- pending_next = (pending & ~dispatch_clear) | irq_req. A request arriving on the same edge as its own dispatch clear stays pending: set wins.
- Masked sources stay pending. They become eligible as soon as they are unmasked.
- A mask write takes effect on the next edge. It does not affect a dispatch already in progress.
- eligible = pending & mask, gated by global_enable.
- States:
  - IDLE -> DISPATCH when state is IDLE and eligible is non-zero. On that edge, register active_id = winner, jump_vector = VEC_BASE + winner*VEC_STRIDE (8-bit arithmetic, wraps mod 256), jump = 1, status = 1.
  - DISPATCH: jump, jump_vector and active_id are held stable. On an edge with jump_ack = 1: jump = 0, pending[active_id] is cleared, and the state moves to SERVICE.
  - SERVICE: status = 1, no new dispatch (no nesting). On clear_status = 1, status = 0 and the state returns to IDLE; active_id keeps its last value.
- clear_status in IDLE or DISPATCH is ignored.
- Dropping global_enable during DISPATCH or SERVICE does not abort the interrupt.
- Latency: irq_req high in cycle k -> pending visible in cycle k+1 -> jump high in cycle k+2, if IDLE, unmasked and enabled. The earliest next dispatch after clear_status is 2 cycles after the clear edge (IDLE re-arbitrates).
- Winner selection (fixed priority): lowest eligible index.
- A reset asserted in any state returns everything to reset values on that edge. The request is dropped and not replayed.

Optional Feature:
IRQ_ROUND_ROBIN_EN. When defined:
- Arbitration is round-robin. Search starts at the pointer and wraps, and the lowest index at or after the pointer wins.
- The pointer becomes (winner+1) mod NUM_SRC on each jump_ack.

When undefined, fixed lowest-index priority is used and the pointer logic is absent.

Decomposition:
- Package irq_pkg: state encoding (IDLE, DISPATCH, SERVICE), VEC_BASE/VEC_STRIDE defaults, the 3-bit id width constant.
- Sub-module irq_priority_select: combinational picker taking eligible and start pointer, returning valid and index. The pointer is tied to 0 when round-robin is disabled.

Test Plan:
- Reset, then pulse irq_req = 4'b0001 for 1 cycle -> 2 cycles later jump = 1, jump_vector = 8'hE0, active_id = 0, status = 1. jump_ack -> jump = 0, pending = 0. clear_status -> status = 0.
- irq_req = 4'b1010 in the same cycle (fixed priority) -> source 1 first (vector 8'hE8). After clear_status, source 3 follows (vector 8'hF8) 2 cycles later.
- Write mask = 8'h0E, pulse source 0 -> no jump, pending = 4'b0001. Write mask = 8'h0F -> jump with vector 8'hE0 two cycles later.
- Hold jump_ack = 0 for 5 cycles during DISPATCH, with a new source 2 pulse -> jump and vector stay stable. Source 2 is pending and is dispatched only after clear_status. A clear_status pulse during DISPATCH is ignored.
- Assert rst while in SERVICE with pending = 4'b0100 -> next cycle status = 0, pending = 0, mask = 4'b1111, jump = 0.
- With IRQ_ROUND_ROBIN_EN, keep sources 0 and 1 continuously requesting -> dispatch order 0, 1, 0, 1.

Source files
------------

// File: rtl/irq_pkg.sv
// Shared types and constants for the interrupt scheduler: FSM states, id width,
// default vector layout and the handler-address helper.
package irq_pkg;

    localparam int unsigned IdW = 3;

    localparam logic [7:0] VecBaseDefault   = 8'hE0;
    localparam logic [7:0] VecStrideDefault = 8'd8;

    typedef enum logic [1:0] {
        StIdle,
        StDispatch,
        StService
    } irq_state_e;

    // Handler address; 8-bit arithmetic so the result wraps mod 256.
    function automatic logic [7:0] vec_addr(logic [7:0] base, logic [7:0] stride,
                                            logic [IdW-1:0] id);
        return base + stride * {5'b0, id};
    endfunction

endpackage

// File: rtl/irq_scheduler_if.sv
// Request/dispatch bundle between peripherals, registers file, rom/decoder and
// the interrupt scheduler. master = scheduler side, slave = surrounding logic.
interface irq_scheduler_if
    import irq_pkg::*;
#(
    parameter int unsigned NUM_SRC = 4
);

    logic [NUM_SRC-1:0] irq_req;
    logic               global_enable;
    logic               mask_w_enable;
    logic [7:0]         mask_w_data;
    logic [NUM_SRC-1:0] mask;
    logic [NUM_SRC-1:0] pending;
    logic               jump;
    logic [7:0]         jump_vector;
    logic               jump_ack;
    logic               clear_status;
    logic               status;
    logic [IdW-1:0]     active_id;

    modport master (
        input  irq_req, global_enable, mask_w_enable, mask_w_data, jump_ack, clear_status,
        output mask, pending, jump, jump_vector, status, active_id
    );

    modport slave (
        output irq_req, global_enable, mask_w_enable, mask_w_data, jump_ack, clear_status,
        input  mask, pending, jump, jump_vector, status, active_id
    );

endinterface

// File: rtl/irq_priority_select.sv
// Combinational picker: first set bit of eligible_i found by searching upward
// from start_i and wrapping. start_i = 0 gives plain lowest-index priority.
module irq_priority_select
    import irq_pkg::*;
#(
    parameter int unsigned NUM_SRC = 4
) (
    input  logic [NUM_SRC-1:0] eligible_i,
    input  logic [IdW-1:0]     start_i,
    output logic               valid_o,
    output logic [IdW-1:0]     idx_o
);

    int unsigned        cand;
    logic [NUM_SRC-1:0] shifted;

    always_comb begin
        valid_o = 1'b0;
        idx_o   = '0;
        cand    = 0;
        shifted = '0;
        for (int unsigned off = 0; off < NUM_SRC; off++) begin
            cand = 32'(start_i) + off;
            if (cand >= NUM_SRC) begin
                cand = cand - NUM_SRC;
            end
            shifted = eligible_i >> cand;
            if (!valid_o && shifted[0]) begin
                valid_o = 1'b1;
                idx_o   = IdW'(cand);
            end
        end
    end

endmodule

// File: rtl/irq_scheduler.sv
// Multi-source interrupt scheduler: latches requests, masks, arbitrates and
// holds one vector jump to rom until acknowledged, then tracks in-service state
// until return-from-interrupt. Define IRQ_ROUND_ROBIN_EN for round-robin arbitration.
module irq_scheduler
    import irq_pkg::*;
#(
    parameter int unsigned NUM_SRC    = 4,
    parameter logic [7:0]  VEC_BASE   = VecBaseDefault,
    parameter logic [7:0]  VEC_STRIDE = VecStrideDefault
) (
    input  logic            clk,
    input  logic            rst,
    irq_scheduler_if.master bus
);

    irq_state_e         state_q, state_d;
    logic [NUM_SRC-1:0] pending_q, pending_d, pending_clr;
    logic [NUM_SRC-1:0] mask_q, mask_d;
    logic               jump_q, jump_d;
    logic [7:0]         vec_q, vec_d;
    logic               status_q, status_d;
    logic [IdW-1:0]     id_q, id_d;

    logic [NUM_SRC-1:0] eligible;
    logic               sel_valid;
    logic [IdW-1:0]     sel_idx;
    logic [IdW-1:0]     sel_start;

`ifdef IRQ_ROUND_ROBIN_EN
    logic [IdW-1:0] ptr_q, ptr_d;
    logic [IdW:0]   ptr_inc;

    assign sel_start = ptr_q;
    assign ptr_inc   = {1'b0, id_q} + 1'b1;

    always_comb begin
        ptr_d = ptr_q;
        if (state_q == StDispatch && bus.jump_ack) begin
            ptr_d = (ptr_inc >= (IdW + 1)'(NUM_SRC)) ? '0 : ptr_inc[IdW-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`else
    assign sel_start = '0;
`endif

    assign eligible = bus.global_enable ? (pending_q & mask_q) : '0;

    irq_priority_select #(
        .NUM_SRC (NUM_SRC)
    ) u_select (
        .eligible_i (eligible),
        .start_i    (sel_start),
        .valid_o    (sel_valid),
        .idx_o      (sel_idx)
    );

    always_comb begin
        state_d     = state_q;
        pending_clr = '0;
        jump_d      = jump_q;
        vec_d       = vec_q;
        status_d    = status_q;
        id_d        = id_q;
        mask_d      = bus.mask_w_enable ? bus.mask_w_data[NUM_SRC-1:0] : mask_q;

        unique case (state_q)
            StIdle: begin
                if (sel_valid) begin
                    state_d  = StDispatch;
                    id_d     = sel_idx;
                    vec_d    = vec_addr(VEC_BASE, VEC_STRIDE, sel_idx);
                    jump_d   = 1'b1;
                    status_d = 1'b1;
                end
            end
            StDispatch: begin
                if (bus.jump_ack) begin
                    state_d     = StService;
                    jump_d      = 1'b0;
                    pending_clr = NUM_SRC'(1) << id_q;
                end
            end
            StService: begin
                if (bus.clear_status) begin
                    state_d  = StIdle;
                    status_d = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase

        // A request on the same edge as its own clear stays pending.
        pending_d = (pending_q & ~pending_clr) | bus.irq_req;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            pending_q <= '0;
            mask_q    <= '1;
            jump_q    <= 1'b0;
            vec_q     <= '0;
            status_q  <= 1'b0;
            id_q      <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            mask_q    <= mask_d;
            jump_q    <= jump_d;
            vec_q     <= vec_d;
            status_q  <= status_d;
            id_q      <= id_d;
        end
    end

    if (NUM_SRC < 8) begin : g_unused_mask
        logic unused_mask_hi;
        assign unused_mask_hi = ^bus.mask_w_data[7:NUM_SRC];
    end

    assign bus.mask        = mask_q;
    assign bus.pending     = pending_q;
    assign bus.jump        = jump_q;
    assign bus.jump_vector = vec_q;
    assign bus.status      = status_q;
    assign bus.active_id   = id_q;

endmodule
